// File: rtl/onehot_decoder_pipe.sv
// Buffered binary-to-one-hot decoder with a 2-entry skid buffer on valid/ready streams.
// Define ONEHOT_DEC_ERR_CNT_EN to add the saturating out-of-range counter port err_count.
module onehot_decoder_pipe #(
  parameter int LINES = 16,
  parameter int WIDTH = $clog2(LINES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bin_valid,
  output logic             bin_ready,
  input  logic [WIDTH-1:0] binary_in,
  output logic             oh_valid,
  input  logic             oh_ready,
  output logic [LINES-1:0] unitary_out,
  output logic             oh_err
`ifdef ONEHOT_DEC_ERR_CNT_EN
  ,
  output logic [7:0]       err_count
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic             accept;
  logic             pop;
  logic [LINES-1:0] new_vec;
  logic             new_err;
  logic [LINES-1:0] head_vec;
  logic             head_err;
  logic [LINES-1:0] skid_vec;
  logic             skid_err;

  assign accept = bin_valid & bin_ready;
  assign pop    = oh_valid & oh_ready;

  // Out-of-range indices match no line, so their vector is naturally all-zero.
  always_comb begin
    new_vec = '0;
    for (int i = 0; i < LINES; i++) begin
      new_vec[i] = (int'(binary_in) == i);
    end
    new_err = (int'(binary_in) >= LINES);
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (accept) state_next = ONE;
      ONE: begin
        if (accept && !pop)      state_next = FULL;
        else if (pop && !accept) state_next = EMPTY;
        else                     state_next = ONE;
      end
      FULL:    if (pop) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  // Handshake outputs are registered from the next state so neither depends on inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      oh_valid  <= 1'b0;
      bin_ready <= 1'b1;
      head_vec  <= '0;
      head_err  <= 1'b0;
      skid_vec  <= '0;
      skid_err  <= 1'b0;
    end else begin
      state     <= state_next;
      oh_valid  <= (state_next != EMPTY);
      bin_ready <= (state_next != FULL);
      case (state)
        EMPTY: begin
          if (accept) begin
            head_vec <= new_vec;
            head_err <= new_err;
          end
        end
        ONE: begin
          if (accept && pop) begin
            head_vec <= new_vec;
            head_err <= new_err;
          end else if (accept) begin
            skid_vec <= new_vec;
            skid_err <= new_err;
          end else if (pop) begin
            head_vec <= '0;
            head_err <= 1'b0;
          end
        end
        FULL: begin
          if (pop) begin
            head_vec <= skid_vec;
            head_err <= skid_err;
          end
        end
        default: begin
          head_vec <= '0;
          head_err <= 1'b0;
        end
      endcase
    end
  end

  assign unitary_out = head_vec;
  assign oh_err      = head_err;

`ifdef ONEHOT_DEC_ERR_CNT_EN
  logic [7:0] err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= 8'd0;
    end else if (accept && new_err && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  assign err_count = err_cnt;
`endif

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// Directed and randomized self-checking bench for onehot_decoder_pipe (LINES=16 and LINES=10).
// Also exercises err_count when ONEHOT_DEC_ERR_CNT_EN is defined.
module tb_onehot_decoder_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_valid = 1'b0, a_ready = 1'b0;
  logic [3:0]  a_idx = '0;
  logic        a_bin_ready, a_oh_valid, a_err;
  logic [15:0] a_unitary;

  logic        b_valid = 1'b0, b_ready = 1'b0;
  logic [3:0]  b_idx = '0;
  logic        b_bin_ready, b_oh_valid, b_err;
  logic [9:0]  b_unitary;
`ifdef ONEHOT_DEC_ERR_CNT_EN
  logic [7:0]  a_cnt, b_cnt;
`endif

  onehot_decoder_pipe #(.LINES(16)) dut_a (
    .clk(clk), .rst(rst),
    .bin_valid(a_valid), .bin_ready(a_bin_ready), .binary_in(a_idx),
    .oh_valid(a_oh_valid), .oh_ready(a_ready),
    .unitary_out(a_unitary), .oh_err(a_err)
`ifdef ONEHOT_DEC_ERR_CNT_EN
    , .err_count(a_cnt)
`endif
  );

  onehot_decoder_pipe #(.LINES(10)) dut_b (
    .clk(clk), .rst(rst),
    .bin_valid(b_valid), .bin_ready(b_bin_ready), .binary_in(b_idx),
    .oh_valid(b_oh_valid), .oh_ready(b_ready),
    .unitary_out(b_unitary), .oh_err(b_err)
`ifdef ONEHOT_DEC_ERR_CNT_EN
    , .err_count(b_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // sel_b chooses the LINES=10 instance.
  task automatic applyStimulus(input bit sel_b, input logic valid, input logic [3:0] idx, input logic ready);
    if (sel_b) begin
      b_valid = valid; b_idx = idx; b_ready = ready;
    end else begin
      a_valid = valid; a_idx = idx; a_ready = ready;
    end
  endtask

  bit [3:0] q[$];
  int sent, got;
  logic [15:0] exp_vec;
  bit acc, pp;

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("rst_valid", a_oh_valid, 0);
    checkOutput("rst_ready", a_bin_ready, 1);
    checkOutput("rst_data", a_unitary, 0);
    checkOutput("rst_err", a_err, 0);
`ifdef ONEHOT_DEC_ERR_CNT_EN
    checkOutput("rst_cnt", b_cnt, 0);
`endif
    rst = 1'b0;

    // Back-to-back stream 0..15 with the consumer always ready.
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) begin
        checkOutput($sformatf("stream_data%0d", i - 1), a_unitary, 32'(1) << (i - 1));
        checkOutput("stream_valid", a_oh_valid, 1);
        checkOutput("stream_ready", a_bin_ready, 1);
        checkOutput("stream_err", a_err, 0);
      end
      if (i < 16) applyStimulus(0, 1, 4'(i), 1);
      else        applyStimulus(0, 0, 4'd0, 1);
      @(negedge clk);
    end
    checkOutput("stream_drained", a_oh_valid, 0);
    checkOutput("stream_drained_data", a_unitary, 0);

    // Stall: 3 then 9 fill head and skid; 5 must be refused while full.
    applyStimulus(0, 1, 4'd3, 0);
    @(negedge clk);
    checkOutput("stall_one_ready", a_bin_ready, 1);
    checkOutput("stall_one_data", a_unitary, 16'h0008);
    applyStimulus(0, 1, 4'd9, 0);
    @(negedge clk);
    checkOutput("stall_full_ready", a_bin_ready, 0);
    checkOutput("stall_full_data", a_unitary, 16'h0008);
    applyStimulus(0, 1, 4'd5, 0);
    @(negedge clk);
    checkOutput("stall_hold_ready", a_bin_ready, 0);
    checkOutput("stall_hold_data", a_unitary, 16'h0008);
    applyStimulus(0, 0, 4'd0, 1);
    @(negedge clk);
    checkOutput("stall_skid_data", a_unitary, 16'h0200);
    checkOutput("stall_skid_ready", a_bin_ready, 1);
    checkOutput("stall_skid_valid", a_oh_valid, 1);
    @(negedge clk);
    checkOutput("stall_empty_valid", a_oh_valid, 0);

    // Reset while full discards both entries.
    applyStimulus(0, 1, 4'd1, 0);
    @(negedge clk);
    applyStimulus(0, 1, 4'd2, 0);
    @(negedge clk);
    checkOutput("prerst_ready", a_bin_ready, 0);
    rst = 1'b1;
    applyStimulus(0, 0, 4'd0, 1);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_valid", a_oh_valid, 0);
    checkOutput("midrst_data", a_unitary, 0);
    checkOutput("midrst_ready", a_bin_ready, 1);
    applyStimulus(0, 1, 4'd7, 0);
    @(negedge clk);
    checkOutput("postrst_data", a_unitary, 16'h0080);
    checkOutput("postrst_valid", a_oh_valid, 1);
    applyStimulus(0, 0, 4'd0, 1);
    @(negedge clk);
    checkOutput("postrst_drained", a_oh_valid, 0);

    // LINES=10: out-of-range flagging and the top in-range line.
    applyStimulus(1, 1, 4'd12, 1);
    @(negedge clk);
    checkOutput("b12_data", b_unitary, 0);
    checkOutput("b12_err", b_err, 1);
    checkOutput("b12_valid", b_oh_valid, 1);
    applyStimulus(1, 1, 4'd5, 1);
    @(negedge clk);
    checkOutput("b5_data", b_unitary, 10'h020);
    checkOutput("b5_err", b_err, 0);
    applyStimulus(1, 1, 4'd9, 1);
    @(negedge clk);
    checkOutput("b9_data", b_unitary, 10'h200);
    checkOutput("b9_err", b_err, 0);
    applyStimulus(1, 1, 4'd10, 1);
    @(negedge clk);
    checkOutput("b10_data", b_unitary, 0);
    checkOutput("b10_err", b_err, 1);
`ifdef ONEHOT_DEC_ERR_CNT_EN
    checkOutput("b_cnt2", b_cnt, 2);
    checkOutput("a_cnt0", a_cnt, 0);
`endif
    for (int i = 0; i < 260; i++) begin
      applyStimulus(1, 1, 4'd15, 1);
      @(negedge clk);
    end
    checkOutput("b15_err", b_err, 1);
    checkOutput("b15_data", b_unitary, 0);
`ifdef ONEHOT_DEC_ERR_CNT_EN
    checkOutput("b_cnt_sat", b_cnt, 255);
`endif
    applyStimulus(1, 0, 4'd0, 1);
    @(negedge clk);
    checkOutput("b_drained", b_oh_valid, 0);

    // Random valid/ready against a FIFO scoreboard.
    sent = 0;
    got = 0;
    for (int cyc = 0; cyc < 60000 && (sent < 10000 || q.size() > 0); cyc++) begin
      if (sent < 10000) applyStimulus(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      else              applyStimulus(0, 0, 4'd0, 1);
      acc = a_valid & a_bin_ready;
      pp  = a_oh_valid & a_ready;
      if (pp) begin
        exp_vec = (q.size() > 0) ? (16'd1 << q.pop_front()) : 16'd0;
        checkOutput("rand_data", a_unitary, exp_vec);
        got++;
      end
      if (acc) begin
        q.push_back(a_idx);
        sent++;
      end
      @(negedge clk);
    end
    checkOutput("rand_sent", sent, 10000);
    checkOutput("rand_got", got, 10000);
    checkOutput("rand_left", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
